// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among N_REQ producers.
// Grants one requester per burst of up to BURST_LEN words and stalls on FIFO full.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                        i_clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
    input  logic                        i_wfull,
    output logic                        o_wr,
    output logic [DATA_WIDTH-1:0]       o_wdata,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_ack,
    output logic                        o_busy,
    output logic [15:0]                 o_wcount
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   last_next;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_next;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               sel_found;
    logic [N_REQ-1:0]   gnt_next;
    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  beat_next;
    logic [CNT_W-1:0]   wcount_next;
    logic               last_beat;

    // First requesting index after the last-granted one, with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((32'(last) + off) % N_REQ);
            if (!sel_found && i_req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign o_busy    = (state == BURST);
    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

    // Next-state logic plus the combinational write-port outputs.
    always_comb begin
        state_next  = state;
        last_next   = last;
        owner_next  = owner;
        gnt_next    = o_gnt;
        beat_next   = beat;
        o_wr        = 1'b0;
        o_ack       = '0;
        o_wdata     = '0;

        if (o_gnt != '0) begin
            o_wdata = i_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH];
        end

        // Reset term keeps the write enable low through an asynchronous reset.
        if (state == BURST) begin
            o_wr = i_req[owner] && !i_wfull && !rst;
        end
        o_ack[owner] = o_wr;
        wcount_next  = o_wcount + CNT_W'(o_wr);

        case (state)
            IDLE: begin
                if (sel_found) begin
                    gnt_next   = N_REQ'(1) << sel_idx;
                    owner_next = sel_idx;
                    beat_next  = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (o_wr) begin
                    beat_next = beat + BEAT_W'(1);
                end
                if (!i_req[owner] || (o_wr && last_beat)) begin
                    last_next  = owner;
                    gnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= IDX_W'(N_REQ - 1);
            owner    <= '0;
            o_gnt    <= '0;
            beat     <= '0;
            o_wcount <= '0;
        end else begin
            state    <= state_next;
            last     <= last_next;
            owner    <= owner_next;
            o_gnt    <= gnt_next;
            beat     <= beat_next;
            o_wcount <= wcount_next;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO among N_REQ producers in the write clock domain.
- Grants one requester at a time for a burst of up to BURST_LEN words and drives the FIFO write data and write enable.
- Stalls on the FIFO full flag without dropping or duplicating data, and acknowledges each accepted word to its owner.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, word width; must match the FIFO data width.
- BURST_LEN, 4, maximum words per grant (1..16).

Ports:
- i_clk  input  1  write-domain clock; the same clock as the FIFO write side.
- rst  input  1  asynchronous, active-high reset.
- i_req  input  N_REQ  per-requester request; high means the word on that requester's i_data slice is valid.
- i_data  input  N_REQ*DATA_WIDTH  packed data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_wfull  input  1  FIFO full flag from the write domain.
- o_wr  output  1  FIFO write enable.
- o_wdata  output  DATA_WIDTH  FIFO write data.
- o_gnt  output  N_REQ  one-hot grant; all zero when idle.
- o_ack  output  N_REQ  one-cycle pulse: requester's current word is accepted this cycle.
- o_busy  output  1  high while in BURST.
- o_wcount  output  16  total words written since reset; wraps modulo 2^16.

Behaviour:
- Reset values:
  - state = IDLE, o_gnt = 0, o_wr = 0, o_ack = 0, o_wdata = 0, o_busy = 0, o_wcount = 0.
  - last-granted pointer = N_REQ-1, so requester 0 has first priority.
  - beat counter = 0.
- Reset is asynchronous: asserting rst mid-burst clears everything immediately. No partial write occurs in the reset cycle.
- States: IDLE and BURST; state and pointer are registered.
- IDLE:
  - If i_req is nonzero, select the first set bit searching from last+1 upward with wrap.
  - Register that selection into o_gnt, clear the beat counter, and go to BURST.
  - Arbitration latency is 1 cycle (request seen in cycle t, first write possible in cycle t+1).
- BURST, owner g (combinational outputs):
  - o_wr = i_req[g] & ~i_wfull.
  - o_wdata = data slice g while o_gnt is nonzero, else 0.
  - o_ack[g] = o_wr; all other o_ack bits are 0.
- Requester handshake:
  - The requester holds its data stable until acked.
  - On an ack it either presents the next word or drops i_req.
- On each write: the beat counter increments and o_wcount increments (wraps 0xFFFF -> 0x0000).
- Exit BURST to IDLE at the clock edge when either:
  - i_req[g] == 0, or
  - a write occurs while beat == BURST_LEN-1.
- On exit: last <= g and o_gnt <= 0. There is one IDLE cycle between consecutive bursts, including re-grants to the same requester.
- Full stall:
  - While i_wfull = 1 in BURST: no write, no ack, beat unchanged, grant held.
  - Stalls do not count toward BURST_LEN.
- If the owner drops i_req while stalled, the burst ends with no write.
- Requests from non-owners are ignored until the next IDLE arbitration. No starvation: each active requester is served within N_REQ bursts.
- Data must never be written while i_wfull = 1. The FIFO's own overflow guard is a backup only.
- o_busy = (state == BURST).

Test Plan:
- Single requester:
  - Stimulus: after reset, i_req = 4'b0001 held, data 1,2,3,... advanced on each ack; i_wfull = 0.
  - Required: o_gnt = 0001 one cycle later; 4 writes of 1..4 on consecutive cycles; one IDLE cycle; next burst writes 5..8; o_wcount = 8.
- Round-robin:
  - Stimulus: i_req = 4'b1111 held, BURST_LEN = 4.
  - Required: grant order 0,1,2,3,0; each burst is exactly 4 writes; o_ack matches the owner only.
- Full stall:
  - Stimulus: during requester 1's burst, after its 2nd write, assert i_wfull for 5 cycles.
  - Required: o_wr = 0 and no ack during the stall; then words 3 and 4 are written; total 4 words, none lost or duplicated.
- Early drop:
  - Stimulus: requester 2 drops i_req after 2 acks.
  - Required: burst ends after 2 writes; next grant goes to requester 3 if it is requesting, else wraps to 0.
- Reset mid-burst:
  - Stimulus: assert rst asynchronously during beat 2.
  - Required: o_wr, o_gnt, o_ack = 0 immediately; o_wcount = 0; after release, requester 0 is granted first.
- Counter wrap:
  - Stimulus: force 65536 writes.
  - Required: o_wcount returns to 0x0000.
